// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC-forward ramp sequencer and its status checker:
// phase codes, FSM state encoding and default ramp/hold timing.
package adc_seq_pkg;

   localparam logic [1:0] PH_RISE    = 2'b00;
   localparam logic [1:0] PH_HOLD_HI = 2'b01;
   localparam logic [1:0] PH_FALL    = 2'b10;
   localparam logic [1:0] PH_HOLD_LO = 2'b11;

   localparam int DEF_RAMP_SPAN   = 100;
   localparam int DEF_STEP        = 1;
   localparam int DEF_HOLD_CYCLES = 100;
   localparam int TMR_WIDTH       = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RISE    = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_FALL    = 3'd3,
      ST_HOLD_LO = 3'd4
   } state_t;

   // IDLE reports the RISE code so phase_out reads 00 when stopped
   function automatic logic [1:0] phase_code(input state_t s);
      case (s)
         ST_HOLD_HI: return PH_HOLD_HI;
         ST_FALL:    return PH_FALL;
         ST_HOLD_LO: return PH_HOLD_LO;
         default:    return PH_RISE;
      endcase
   endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Loadable down-counter with terminal-count flag; times both the ramp steps
// and the hold phases of the sequencer.
module adc_seq_timer
   import adc_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [TMR_WIDTH-1:0] load_val,
   input  logic                 en,
   output logic                 tc
);

   logic [TMR_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - TMR_WIDTH'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/adc_ramp_sequencer.sv
// Trapezoid stimulus sequencer (RISE, HOLD_HI, FALL, HOLD_LO) feeding the
// ADC-forward status checker.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_IDLE    | not running; count_out holds the base for the next run
//   ST_RISE    | count_out += STEP each cycle
//   ST_HOLD_HI | count_out held at the top
//   ST_FALL    | count_out -= STEP each cycle
//   ST_HOLD_LO | count_out held at the base; period ends on leaving
module adc_ramp_sequencer
   import adc_seq_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int RAMP_SPAN   = DEF_RAMP_SPAN,
   parameter int STEP        = DEF_STEP,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             use_ext,
   input  logic             ext_advance,
   input  logic [7:0]       num_periods,
   output logic [1:0]       phase_out,
   output logic [WIDTH-1:0] count_out,
   output logic             busy,
   output logic             done,
   output logic [7:0]       period_cnt,
   output logic             sat_err
);

   // timer counts down to zero, so load one less than the phase length
   localparam logic [TMR_WIDTH-1:0] RAMP_LOAD = TMR_WIDTH'(RAMP_SPAN / STEP - 1);
   localparam logic [TMR_WIDTH-1:0] HOLD_LOAD = TMR_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [WIDTH:0]       STEP_EXT  = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH:0]       MAX_EXT   = {1'b0, {WIDTH{1'b1}}};

   state_t               state, state_nxt;
   logic                 ext_mode;
   logic [7:0]           num_lat;
   logic                 tmr_load, tmr_tc;
   logic [TMR_WIDTH-1:0] tmr_load_val;
   logic                 adv, start_acc, period_end, run_end;
   logic [7:0]           period_inc;
   logic [WIDTH:0]       count_up, count_dn;
   logic [WIDTH-1:0]     count_nxt;
   logic                 sat_hit;

   adc_seq_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (state != ST_IDLE),
      .tc       (tmr_tc)
   );

   assign adv        = ext_mode ? ext_advance : tmr_tc;
   assign period_inc = period_cnt + 8'd1;
   assign count_up   = {1'b0, count_out} + STEP_EXT;
   assign count_dn   = {1'b0, count_out} - STEP_EXT;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      tmr_load     = 1'b0;
      tmr_load_val = RAMP_LOAD;
      start_acc    = 1'b0;
      period_end   = 1'b0;
      run_end      = 1'b0;
      case (state)
         ST_IDLE: if (start) begin
            state_nxt = ST_RISE;
            start_acc = 1'b1;
            tmr_load  = 1'b1;
         end
         ST_RISE: if (adv) begin
            state_nxt    = ST_HOLD_HI;
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LOAD;
         end
         ST_HOLD_HI: if (adv) begin
            state_nxt = ST_FALL;
            tmr_load  = 1'b1;
         end
         ST_FALL: if (adv) begin
            state_nxt    = ST_HOLD_LO;
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LOAD;
         end
         ST_HOLD_LO: if (adv) begin
            period_end = 1'b1;
            if ((num_lat != 8'd0) && (period_inc == num_lat)) begin
               state_nxt = ST_IDLE;
               run_end   = 1'b1;
            end else begin
               state_nxt = ST_RISE;
               tmr_load  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // stop overrides everything, including a same-cycle start
      if (stop) begin
         state_nxt  = ST_IDLE;
         tmr_load   = 1'b0;
         start_acc  = 1'b0;
         period_end = 1'b0;
         run_end    = 1'b0;
      end
   end

   always_comb begin
      count_nxt = count_out;
      sat_hit   = 1'b0;
      if (!stop) begin
         if (state == ST_RISE) begin
            if (count_up > MAX_EXT) begin
               count_nxt = '1;
               sat_hit   = 1'b1;
            end else begin
               count_nxt = count_up[WIDTH-1:0];
            end
         end else if (state == ST_FALL) begin
            if (count_dn[WIDTH]) begin
               count_nxt = '0;
               sat_hit   = 1'b1;
            end else begin
               count_nxt = count_dn[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_out  <= PH_RISE;
         count_out  <= '0;
         done       <= 1'b0;
         period_cnt <= 8'd0;
         sat_err    <= 1'b0;
         ext_mode   <= 1'b0;
         num_lat    <= 8'd0;
      end else begin
         phase_out <= phase_code(state_nxt);
         count_out <= count_nxt;
         done      <= run_end;
         if (start_acc) begin
            period_cnt <= 8'd0;
            sat_err    <= 1'b0;
            ext_mode   <= use_ext;
            num_lat    <= num_periods;
         end else begin
            if (period_end) period_cnt <= period_inc;
            if (sat_hit)    sat_err    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_ramp_sequencer.sv
// Self-checking bench for adc_ramp_sequencer: default instance plus a narrow
// 8-bit instance used to reach saturation quickly.
module tb_adc_ramp_sequencer;

   localparam int N    = 100;
   localparam int H    = 100;
   localparam int P    = 2 * N + 2 * H;
   localparam int MAXV = 65535;
   localparam int NS   = 10;
   localparam int HS   = 3;
   localparam int PS   = 2 * NS + 2 * HS;
   localparam int MAXS = 255;

   logic        clk, rst_n, start, stop, use_ext, ext_advance;
   logic [7:0]  num_periods;
   logic [1:0]  phase_out, phase_s;
   logic [15:0] count_out;
   logic [7:0]  count_s;
   logic        busy, done, sat_err, busy_s, done_s, sat_s;
   logic [7:0]  period_cnt, pcnt_s;

   int n_checks = 0;
   int n_bad    = 0;

   adc_ramp_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .use_ext(use_ext),
      .ext_advance(ext_advance), .num_periods(num_periods), .phase_out(phase_out),
      .count_out(count_out), .busy(busy), .done(done), .period_cnt(period_cnt),
      .sat_err(sat_err)
   );

   adc_ramp_sequencer #(.WIDTH(8), .RAMP_SPAN(40), .STEP(4), .HOLD_CYCLES(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .use_ext(use_ext),
      .ext_advance(ext_advance), .num_periods(num_periods), .phase_out(phase_s),
      .count_out(count_s), .busy(busy_s), .done(done_s), .period_cnt(pcnt_s),
      .sat_err(sat_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // {phase, busy, done, sat, period_cnt, count}
   function automatic logic [28:0] act_main();
      return {phase_out, busy, done, sat_err, period_cnt, count_out};
   endfunction

   function automatic logic [28:0] act_small();
      return {phase_s, busy_s, done_s, sat_s, pcnt_s, 8'h00, count_s};
   endfunction

   // Expected outputs t edges after the start edge of an internally timed run
   function automatic logic [28:0] model_int(input int t, input int base, input int num,
                                             input int n, input int h, input int step,
                                             input int span, input int maxv);
      int per, full, b, hi, u, cnt, pc;
      logic [1:0] ph;
      logic bz, dn, sat;
      per  = 2 * n + 2 * h;
      full = t / per;
      b    = base;
      sat  = 1'b0;
      if (num != 0 && full > num) full = num;
      for (int p = 0; p < full; p++) begin
         if (b + span > maxv) sat = 1'b1;
         hi = (b + span > maxv) ? maxv : b + span;
         b  = hi - span;
      end
      hi = (b + span > maxv) ? maxv : b + span;
      if (num != 0 && t >= num * per) begin
         ph = 2'b00; bz = 1'b0; dn = (t == num * per); pc = num; cnt = b;
      end else begin
         bz = 1'b1; dn = 1'b0; pc = full; u = t % per;
         if (u < n) begin
            ph  = 2'b00;
            cnt = b + u * step;
            if (cnt > maxv) begin cnt = maxv; sat = 1'b1; end
         end else begin
            if (b + span > maxv) sat = 1'b1;
            if (u < n + h) begin
               ph = 2'b01; cnt = hi;
            end else if (u < 2 * n + h) begin
               ph = 2'b10; cnt = hi - (u - n - h) * step;
            end else begin
               ph = 2'b11; cnt = hi - span;
            end
         end
      end
      return {ph, bz, dn, sat, 8'(pc), 16'(cnt)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 0; stop = 0; use_ext = 0; ext_advance = 0; num_periods = 8'd0;
      rst_n = 1'b0;
      #7;
      rst_n = 1'b1;
      tick();
   endtask

   // Leaves count_out = r on the default instance (r <= 99) after a reset
   task automatic preload(input int r);
      use_ext = 0; num_periods = 8'd0;
      start = 1; tick(); start = 0;
      repeat (r) tick();
      stop = 1; tick(); stop = 0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; stop = 0; use_ext = 0; ext_advance = 0; num_periods = 8'd0;
      #2;
      n_checks++;
      if (act_main() !== 29'd0) begin
         n_bad++; $display("FAIL reset_hold actual=%h expected=%h", act_main(), 29'd0);
      end
      #5;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (act_main() !== 29'd0) begin
         n_bad++; $display("FAIL reset_release actual=%h expected=%h", act_main(), 29'd0);
      end
      n_checks++;
      if (act_small() !== 29'd0) begin
         n_bad++; $display("FAIL reset_small actual=%h expected=%h", act_small(), 29'd0);
      end
   endtask

   task automatic test_single_period();
      logic [28:0] exp_v;
      int dones = 0;
      do_reset();
      num_periods = 8'd1; use_ext = 0;
      start = 1; tick(); start = 0;
      for (int t = 0; t <= P + 2; t++) begin
         if (t > 0) tick();
         exp_v = model_int(t, 0, 1, N, H, 1, N, MAXV);
         if (done) dones++;
         n_checks++;
         if (act_main() !== exp_v) begin
            n_bad++; $display("FAIL single_trace t=%0d actual=%h expected=%h", t, act_main(), exp_v);
         end
      end
      n_checks++;
      if (dones != 1) begin
         n_bad++; $display("FAIL single_done_count actual=%0d expected=1", dones);
      end
   endtask

   task automatic test_multi_period();
      logic [28:0] exp_v;
      int base, num;
      int dones = 0;
      do_reset();
      base = $urandom_range(1, 99);
      preload(base);
      num = $urandom_range(2, 3);
      num_periods = 8'(num); use_ext = 0;
      start = 1; tick(); start = 0;
      for (int t = 0; t <= num * P + 2; t++) begin
         if (t > 0) tick();
         exp_v = model_int(t, base, num, N, H, 1, N, MAXV);
         if (done) dones++;
         n_checks++;
         if (act_main() !== exp_v) begin
            n_bad++; $display("FAIL multi_trace t=%0d base=%0d actual=%h expected=%h", t, base, act_main(), exp_v);
         end
      end
      n_checks++;
      if (dones != 1 || period_cnt !== 8'(num)) begin
         n_bad++; $display("FAIL multi_end dones=%0d pcnt=%0d expected dones=1 pcnt=%0d", dones, period_cnt, num);
      end
   endtask

   task automatic test_stop();
      logic [28:0] exp_v;
      int base;
      int dones = 0;
      do_reset();
      base = $urandom_range(1, 99);
      preload(base);
      num_periods = 8'd0; use_ext = 0;
      start = 1; tick(); start = 0;
      repeat (150) tick();
      exp_v = model_int(150, base, 0, N, H, 1, N, MAXV);
      n_checks++;
      if (act_main() !== exp_v) begin
         n_bad++; $display("FAIL stop_before actual=%h expected=%h", act_main(), exp_v);
      end
      stop = 1; tick(); stop = 0;
      exp_v = {2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 16'(base + N)};
      n_checks++;
      if (act_main() !== exp_v) begin
         n_bad++; $display("FAIL stop_idle actual=%h expected=%h", act_main(), exp_v);
      end
      repeat (5) begin
         tick();
         if (done) dones++;
      end
      n_checks++;
      if (dones != 0 || count_out !== 16'(base + N)) begin
         n_bad++; $display("FAIL stop_after dones=%0d count=%0d expected dones=0 count=%0d", dones, count_out, base + N);
      end
   endtask

   task automatic test_saturation();
      logic [28:0] exp_v;
      int r;
      do_reset();
      use_ext = 1; num_periods = 8'd0;
      start = 1; tick(); start = 0;
      r = $urandom_range(54, 63);
      repeat (r) tick();
      stop = 1; tick(); stop = 0;
      use_ext = 0;
      n_checks++;
      if (count_s !== 8'(4 * r) || sat_s !== 1'b0) begin
         n_bad++; $display("FAIL sat_preload count=%0d sat=%0b expected count=%0d sat=0", count_s, sat_s, 4 * r);
      end
      num_periods = 8'd1;
      start = 1; tick(); start = 0;
      for (int t = 0; t <= PS + 1; t++) begin
         if (t > 0) tick();
         exp_v = model_int(t, 4 * r, 1, NS, HS, 4, 40, MAXS);
         n_checks++;
         if (act_small() !== exp_v) begin
            n_bad++; $display("FAIL sat_trace t=%0d base=%0d actual=%h expected=%h", t, 4 * r, act_small(), exp_v);
         end
      end
      start = 1; tick(); start = 0;
      n_checks++;
      if (sat_s !== 1'b0 || busy_s !== 1'b1) begin
         n_bad++; $display("FAIL sat_clear_on_start sat=%0b busy=%0b expected sat=0 busy=1", sat_s, busy_s);
      end
      stop = 1; tick(); stop = 0;
   endtask

   task automatic test_ext_mode();
      int pulses [4] = '{20, 50, 60, 90};
      int k, cnt, lo;
      logic [28:0] exp_v;
      do_reset();
      ext_advance = 1; tick(); ext_advance = 0;
      n_checks++;
      if (act_main() !== 29'd0) begin
         n_bad++; $display("FAIL ext_idle_ignored actual=%h expected=%h", act_main(), 29'd0);
      end
      use_ext = 1; num_periods = 8'd0;
      start = 1; tick(); start = 0;
      lo = (pulses[0] + 1) - (pulses[2] - pulses[1]);
      for (int t = 0; t <= 100; t++) begin
         if (t > 0) tick();
         k = 0;
         foreach (pulses[i]) if (pulses[i] < t) k++;
         cnt = (t <= pulses[0] + 1) ? t : pulses[0] + 1;
         if (t > pulses[1] + 1)
            cnt -= (((t < pulses[2] + 1) ? t : pulses[2] + 1) - (pulses[1] + 1));
         if (t > pulses[3] + 1) cnt = lo + (t - (pulses[3] + 1));
         exp_v = {2'(k % 4), 1'b1, 1'b0, 1'b0, 8'((k >= 4) ? 1 : 0), 16'(cnt)};
         n_checks++;
         if (act_main() !== exp_v) begin
            n_bad++; $display("FAIL ext_trace t=%0d actual=%h expected=%h", t, act_main(), exp_v);
         end
         if (t == pulses[0]) begin
            n_checks++;
            if (count_out !== 16'd20) begin
               n_bad++; $display("FAIL ext_first_pulse_count actual=%0d expected=20", count_out);
            end
         end
         ext_advance = (t == pulses[0] || t == pulses[1] || t == pulses[2] || t == pulses[3]);
      end
      ext_advance = 0;
      stop = 1; tick(); stop = 0;
      use_ext = 0;
   endtask

   task automatic test_misc();
      logic [28:0] exp_v;
      int dones = 0;
      do_reset();
      num_periods = 8'd1;
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      n_checks++;
      if (act_main() !== 29'd0) begin
         n_bad++; $display("FAIL start_stop_same actual=%h expected=%h", act_main(), 29'd0);
      end
      start = 1; tick(); start = 0;
      for (int t = 0; t <= P + 1; t++) begin
         if (t > 0) tick();
         exp_v = model_int(t, 0, 1, N, H, 1, N, MAXV);
         if (done) dones++;
         n_checks++;
         if (act_main() !== exp_v) begin
            n_bad++; $display("FAIL busy_start_trace t=%0d actual=%h expected=%h", t, act_main(), exp_v);
         end
         if (t == 10) begin start = 1; num_periods = 8'd5; use_ext = 1; end
         if (t == 11) begin start = 0; num_periods = 8'd1; use_ext = 0; end
      end
      n_checks++;
      if (dones != 1) begin
         n_bad++; $display("FAIL busy_start_done_count actual=%0d expected=1", dones);
      end
      num_periods = 8'd0;
      start = 1; tick(); start = 0;
      repeat (250) tick();
      n_checks++;
      if (phase_out !== 2'b10) begin
         n_bad++; $display("FAIL midfall_phase actual=%0d expected=2", phase_out);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (act_main() !== 29'd0 || act_small() !== 29'd0) begin
         n_bad++; $display("FAIL async_reset actual=%h small=%h expected=%h", act_main(), act_small(), 29'd0);
      end
      #2 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_period();
      test_multi_period();
      test_stop();
      test_saturation();
      test_ext_mode();
      test_misc();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
